// File: rtl/lockout_penalty_timer_pkg.sv
// Shared definitions for the lockout penalty timer slice.
//   state_t        : FSM state encoding (3-bit)
//   DEF_BASE_SEC   : default penalty seconds for error count 1
//   DEF_PERM_ERR   : default error count that forces a permanent lock
//   clamp_err()    : maps an error count of 0 to 1
package lockout_penalty_timer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    COUNT     = 3'd2,
    RELEASE   = 3'd3,
    PERM_LOCK = 3'd4
  } state_t;

  localparam int unsigned DEF_BASE_SEC = 5;
  localparam int unsigned DEF_PERM_ERR = 7;

  // A lock request arriving with a zero count still earns the base penalty.
  function automatic logic [2:0] clamp_err(input logic [2:0] e);
    return (e == 3'd0) ? 3'd1 : e;
  endfunction

endpackage

// File: rtl/lockout_penalty_timer_if.sv
// Handshake between the wrong-code error processor and the penalty timer.
//   gen_stop      : lock request from the error processor (async to clk)
//   error_counter : saturating 3-bit error count
//   rst_out       : release pulse back to the error processor
// master = error processor side, slave = penalty timer side.
interface lockout_penalty_timer_if;
  logic       gen_stop;
  logic [2:0] error_counter;
  logic       rst_out;

  modport master (output gen_stop, output error_counter, input  rst_out);
  modport slave  (input  gen_stop, input  error_counter, output rst_out);
endinterface

// File: rtl/lockout_penalty_timer_sec_prescaler.sv
// 1 Hz tick generator shared by the door-lock timers.
//   clk     : system clock
//   gen_rst : asynchronous active-high reset
//   clr     : synchronous clear of the divider (wins over en)
//   en      : count enable
//   tick    : one-cycle pulse on the divider terminal count (CLK_HZ-1)
module sec_prescaler #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic gen_rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge gen_rst) begin
    if (gen_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == TC) cnt <= '0;
      else           cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && !clr && (cnt == TC);

endmodule

// File: rtl/lockout_penalty_timer.sv
// Keypad lockout timer downstream of the wrong-code error processor.
// Penalty doubles per consecutive error; count PERM_ERR locks permanently.
//   clk           : system clock, rising edge
//   gen_rst       : asynchronous active-high reset
//   err_if        : gen_stop / error_counter in, rst_out (release pulse) out
//   admin_clear   : synchronous override back to IDLE from any state
//   keypad_lock   : keypad entry blocked
//   perm_lock     : permanent lock active
//   remaining_sec : seconds left in the current penalty, 0 outside COUNT
//   buzzer        : first second of COUNT, and throughout PERM_LOCK
// All outputs are registered from the next-state decode.
module lockout_penalty_timer
  import lockout_penalty_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BASE_SEC = DEF_BASE_SEC,
  parameter int unsigned PERM_ERR = DEF_PERM_ERR,
  parameter int unsigned SEC_W    = 8
) (
  input  logic                 clk,
  input  logic                 gen_rst,
  lockout_penalty_timer_if.slave err_if,
  input  logic                 admin_clear,
  output logic                 keypad_lock,
  output logic                 perm_lock,
  output logic [SEC_W-1:0]     remaining_sec,
  output logic                 buzzer
);

  state_t state, next_state;

  logic             sync_ff1, stop_s;
  logic             tick;
  logic [2:0]       err_eff;
  logic [SEC_W-1:0] load_sec;
  logic [SEC_W-1:0] rem_n;
  logic             lock_n, perm_n, rst_n, buzz_n;

  // 2-FF synchroniser for the asynchronous lock request
  always_ff @(posedge clk or posedge gen_rst) begin
    if (gen_rst) begin
      sync_ff1 <= 1'b0;
      stop_s   <= 1'b0;
    end else begin
      sync_ff1 <= err_if.gen_stop;
      stop_s   <= sync_ff1;
    end
  end

  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk     (clk),
    .gen_rst (gen_rst),
    .clr     ((state == ARM) || admin_clear),
    .en      (state == COUNT),
    .tick    (tick)
  );

  assign err_eff  = clamp_err(err_if.error_counter);
  assign load_sec = SEC_W'(BASE_SEC) << (err_eff - 3'd1);

  always_ff @(posedge clk or posedge gen_rst) begin
    if (gen_rst) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    rem_n      = remaining_sec;

    case (state)
      IDLE:      if (stop_s) next_state = ARM;
      ARM:       next_state = (32'(err_eff) >= PERM_ERR) ? PERM_LOCK : COUNT;
      COUNT:     if (remaining_sec == '0) next_state = RELEASE;
      RELEASE:   if (!stop_s) next_state = IDLE;
      PERM_LOCK: next_state = PERM_LOCK;
      default:   next_state = IDLE;
    endcase

    if (admin_clear) next_state = IDLE;

    if (admin_clear)                              rem_n = '0;
    else if (state == ARM && next_state == COUNT) rem_n = load_sec;
    else if (state == COUNT && tick)              rem_n = remaining_sec - SEC_W'(1);
    else if (next_state != COUNT)                 rem_n = '0;

    lock_n = (next_state != IDLE);
    perm_n = (next_state == PERM_LOCK);
    rst_n  = (next_state == RELEASE);
    // buzzer starts on ARM->COUNT and holds until the first seconds tick
    buzz_n = (next_state == PERM_LOCK) ||
             ((next_state == COUNT) && ((state == ARM) || (buzzer && !tick)));
  end

  always_ff @(posedge clk or posedge gen_rst) begin
    if (gen_rst) begin
      keypad_lock    <= 1'b0;
      perm_lock      <= 1'b0;
      err_if.rst_out <= 1'b0;
      remaining_sec  <= '0;
      buzzer         <= 1'b0;
    end else begin
      keypad_lock    <= lock_n;
      perm_lock      <= perm_n;
      err_if.rst_out <= rst_n;
      remaining_sec  <= rem_n;
      buzzer         <= buzz_n;
    end
  end

endmodule

// File: tb/tb_lockout_penalty_timer.sv
// Self-checking bench for lockout_penalty_timer (CLK_HZ=10, BASE_SEC=5).
module tb_lockout_penalty_timer;

  logic       clk = 1'b0;
  logic       gen_rst;
  logic       admin_clear;
  logic       keypad_lock, perm_lock, buzzer;
  logic [7:0] remaining_sec;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  lockout_penalty_timer_if eif();

  lockout_penalty_timer #(
    .CLK_HZ   (10),
    .BASE_SEC (5),
    .PERM_ERR (7),
    .SEC_W    (8)
  ) dut (
    .clk           (clk),
    .gen_rst       (gen_rst),
    .err_if        (eif),
    .admin_clear   (admin_clear),
    .keypad_lock   (keypad_lock),
    .perm_lock     (perm_lock),
    .remaining_sec (remaining_sec),
    .buzzer        (buzzer)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stop;
    logic [2:0]  ec;
    int unsigned adv;
    logic        lock;
    logic        rst;
    logic        perm;
    logic [7:0]  rem;
    logic        buzz;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic lk, input logic rs,
                         input logic pm, input logic [7:0] rm, input logic bz);
    chk({name, ".lock"}, int'(keypad_lock), int'(lk));
    chk({name, ".rst_out"}, int'(eif.rst_out), int'(rs));
    chk({name, ".perm"}, int'(perm_lock), int'(pm));
    chk({name, ".rem"}, int'(remaining_sec), int'(rm));
    chk({name, ".buzz"}, int'(buzzer), int'(bz));
  endtask

  initial begin
    int unsigned n;
    logic        seen;

    // err=1 walk-through, timing counted from the edge after gen_stop rises
    vecs[0]  = '{1'b1, 3'd1, 3,  1'b1, 1'b0, 1'b0, 8'd0, 1'b0}; // ARM
    vecs[1]  = '{1'b1, 3'd1, 1,  1'b1, 1'b0, 1'b0, 8'd5, 1'b1}; // COUNT entry
    vecs[2]  = '{1'b1, 3'd1, 9,  1'b1, 1'b0, 1'b0, 8'd5, 1'b1}; // last clk of 1st second
    vecs[3]  = '{1'b1, 3'd1, 1,  1'b1, 1'b0, 1'b0, 8'd4, 1'b0};
    vecs[4]  = '{1'b1, 3'd1, 10, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0};
    vecs[5]  = '{1'b1, 3'd1, 10, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0};
    vecs[6]  = '{1'b1, 3'd1, 10, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[7]  = '{1'b1, 3'd1, 10, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[8]  = '{1'b1, 3'd1, 1,  1'b1, 1'b1, 1'b0, 8'd0, 1'b0}; // RELEASE
    vecs[9]  = '{1'b1, 3'd1, 5,  1'b1, 1'b1, 1'b0, 8'd0, 1'b0}; // holds while stop high
    vecs[10] = '{1'b0, 3'd1, 1,  1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[11] = '{1'b0, 3'd1, 1,  1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[12] = '{1'b0, 3'd1, 1,  1'b0, 1'b0, 1'b0, 8'd0, 1'b0}; // back to IDLE

    gen_rst           = 1'b1;
    admin_clear       = 1'b0;
    eif.gen_stop      = 1'b0;
    eif.error_counter = 3'd0;
    step(3);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    gen_rst = 1'b0;
    step(2);
    chk_all("idle", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      eif.gen_stop      = vecs[i].stop;
      eif.error_counter = vecs[i].ec;
      step(vecs[i].adv);
      chk_all($sformatf("vec%0d", i), vecs[i].lock, vecs[i].rst,
              vecs[i].perm, vecs[i].rem, vecs[i].buzz);
    end

    // err=3: loads 20, reaches 0 exactly 200 clk after loading
    eif.gen_stop = 1'b1; eif.error_counter = 3'd3;
    n = 0;
    do begin step(1); n++; end while (remaining_sec == 8'd0 && n < 20);
    chk("err3.load_latency", int'(n), 4);
    chk("err3.load", int'(remaining_sec), 20);
    n = 0;
    while (remaining_sec != 8'd0 && n < 300) begin step(1); n++; end
    chk("err3.duration", int'(n), 200);
    step(1);
    chk("err3.rst_out", int'(eif.rst_out), 1);
    eif.gen_stop = 1'b0;
    step(3);
    chk_all("err3.done", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // err=7: permanent lock, no release for 1000 clk
    eif.gen_stop = 1'b1; eif.error_counter = 3'd7;
    step(4);
    chk_all("perm", 1'b1, 1'b0, 1'b1, 8'd0, 1'b1);
    eif.gen_stop = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (eif.rst_out || !perm_lock) seen = 1'b1;
    end
    chk("perm.hold_1000", int'(seen), 0);
    admin_clear = 1'b1;
    step(1);
    admin_clear = 1'b0;
    chk_all("perm.clear", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step(5);
    chk_all("perm.cleared_idle", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // err=0 treated as 1, then admin_clear abort at remaining_sec=3
    eif.gen_stop = 1'b1; eif.error_counter = 3'd0;
    step(4);
    chk_all("err0", 1'b1, 1'b0, 1'b0, 8'd5, 1'b1);
    eif.gen_stop = 1'b0;
    n = 0;
    while (remaining_sec != 8'd3 && n < 100) begin step(1); n++; end
    chk("abort.reach3", int'(remaining_sec), 3);
    admin_clear = 1'b1;
    step(1);
    admin_clear = 1'b0;
    chk_all("abort", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (eif.rst_out || keypad_lock) seen = 1'b1;
    end
    chk("abort.stays_idle", int'(seen), 0);

    // gen_rst mid-RELEASE: rst_out drops without waiting for a clock edge
    eif.gen_stop = 1'b1; eif.error_counter = 3'd1;
    n = 0;
    while (!eif.rst_out && n < 100) begin step(1); n++; end
    chk("rstrel.reached", int'(eif.rst_out), 1);
    #3 gen_rst = 1'b1;
    #1;
    chk("rstrel.rst_out_async", int'(eif.rst_out), 0);
    chk("rstrel.lock_async", int'(keypad_lock), 0);
    eif.gen_stop = 1'b0;
    step(2);
    gen_rst = 1'b0;
    step(4);
    chk_all("rstrel.idle", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
